// File: rtl/sub_serial.sv
// Bit-serial subtractor: LSB-first ripple of a-b over WIDTH cycles, IDLE/SUB/DONE handshake on en.
// Optional macro SUB_SERIAL_OVF_EN adds the ovf output (signed overflow of the final result).
module sub_serial #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             borrow,
  output logic             done
`ifdef SUB_SERIAL_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic            br;
  logic [CW-1:0]   count;

  logic d_c;
  logic nb_c;
  logic last_c;

  // One full-subtractor slice on the current LSBs
  assign d_c    = a_reg[0] ^ b_reg[0] ^ br;
  assign nb_c   = (~a_reg[0] & b_reg[0]) | (~a_reg[0] & br) | (b_reg[0] & br);
  assign last_c = (count == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_reg  <= '0;
      b_reg  <= '0;
      br     <= 1'b0;
      count  <= '0;
      out    <= '0;
      borrow <= 1'b0;
      done   <= 1'b0;
`ifdef SUB_SERIAL_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            a_reg <= a;
            b_reg <= b;
            out   <= '0;
            br    <= 1'b0;
            count <= '0;
`ifdef SUB_SERIAL_OVF_EN
            ovf   <= 1'b0;
`endif
            state <= SUB;
          end
        end
        SUB: begin
          out   <= {d_c, out[WIDTH-1:1]};
          a_reg <= a_reg >> 1;
          b_reg <= b_reg >> 1;
          br    <= nb_c;
          // count stops at WIDTH-1 so it never wraps for power-of-two widths
          if (last_c) begin
            borrow <= nb_c;
`ifdef SUB_SERIAL_OVF_EN
            ovf    <= (a_reg[0] ^ b_reg[0]) & (d_c ^ a_reg[0]);
`endif
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            count <= count + CW'(1);
          end
        end
        DONE: begin
          if (!en) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sub_serial.sv
// Randomized scoreboard bench for sub_serial; expected results come from integer arithmetic.
// Honours SUB_SERIAL_OVF_EN to also check the ovf output.
module tb_sub_serial;

  localparam int unsigned W = 8;

  typedef struct packed {
    logic [W-1:0] res;
    logic         br;
    logic         ov;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         en;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] out;
  logic         borrow;
  logic         done;
  logic         ovf_obs;

`ifdef SUB_SERIAL_OVF_EN
  logic ovf;
  assign ovf_obs = ovf;
`else
  assign ovf_obs = 1'b0;
`endif

  sub_serial #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .a      (a),
    .b      (b),
    .out    (out),
    .borrow (borrow),
    .done   (done)
`ifdef SUB_SERIAL_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  exp_t cur;
  logic done_q = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: plain unsigned/signed integer subtraction
  function automatic exp_t model(input int unsigned x, input int unsigned y);
    exp_t r;
    int   sx;
    int   sy;
    int   sd;
    r.res = W'(x - y);
    r.br  = (x < y);
    sx = (x >= (1 << (W - 1))) ? int'(x) - (1 << W) : int'(x);
    sy = (y >= (1 << (W - 1))) ? int'(y) - (1 << W) : int'(y);
    sd = sx - sy;
`ifdef SUB_SERIAL_OVF_EN
    r.ov = (sd > (1 << (W - 1)) - 1) || (sd < -(1 << (W - 1)));
`else
    r.ov = 1'b0;
`endif
    return r;
  endfunction

  // Monitor: pops on each rising done, then checks the result stays frozen while done is high
  always @(negedge clk) begin
    if (!rst) begin
      if (done && !done_q) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got done=1 expected no pending op at %0t", $time);
        end else begin
          cur = sb.pop_front();
          chk("result_out", 32'(out), 32'(cur.res));
          chk("result_borrow", 32'(borrow), 32'(cur.br));
          chk("result_ovf", 32'(ovf_obs), 32'(cur.ov));
        end
      end else if (done && done_q) begin
        chk("done_hold_out", 32'(out), 32'(cur.res));
        chk("done_hold_borrow", 32'(borrow), 32'(cur.br));
      end
    end
    done_q = done;
  end

  // One full operation; hold = extra cycles en stays high in DONE
  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input int hold);
    exp_t e;
    int   edges;
    bit   got;
    e = model(x, y);
    sb.push_back(e);
    a  = x;
    b  = y;
    en = 1'b1;
    @(posedge clk); #1;
    chk("busy_after_start", 32'(done), 32'd0);
    edges = 0;
    got   = 1'b0;
    while (!got && edges < int'(W) + 3) begin
      a  = W'($urandom);
      b  = W'($urandom);
      en = 1'($urandom);
      @(posedge clk); #1;
      edges++;
      if (done) got = 1'b1;
    end
    // start edge plus W SUB edges: done rises W edges after the sampling edge
    chk("done_latency", 32'(edges), 32'(W));
    en = (hold > 0);
    for (int i = 0; i < hold; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      @(posedge clk); #1;
      chk("stay_done", 32'(done), 32'd1);
    end
    en = 1'b0;
    @(posedge clk); #1;
    chk("back_idle", 32'(done), 32'd0);
    chk("persist_out", 32'(out), 32'(e.res));
    chk("persist_borrow", 32'(borrow), 32'(e.br));
    repeat ($urandom_range(0, 2)) begin
      a = W'($urandom);
      b = W'($urandom);
      @(posedge clk); #1;
      chk("idle_hold", 32'(out), 32'(e.res));
    end
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    a   = '0;
    b   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out", 32'(out), 32'd0);
    chk("reset_borrow", 32'(borrow), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    do_op(8'd200, 8'd55, 0);
    do_op(8'd5, 8'd9, 0);
    do_op(8'h80, 8'h01, 0);
    do_op(8'h7F, 8'hFF, 0);
    do_op(8'h00, 8'h00, 0);
    do_op(8'd5, 8'd9, 10);

    // Abort on the 4th SUB cycle after a borrow=1 result
    a  = 8'hC3;
    b  = 8'h5A;
    en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_out", 32'(out), 32'd0);
    chk("abort_borrow", 32'(borrow), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op(8'hC3, 8'h5A, 0);

    for (int n = 0; n < 40; n++)
      do_op(W'($urandom), W'($urandom), int'($urandom_range(0, 3)));

    @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test expected finish before 2ms");
    $fatal(1, "watchdog");
  end

endmodule
